eprisc_mem_bridge: RTL and testbench
====================================

Name: eprisc_mem_bridge

Overview:
- Bus bridge between the epRISC core's memory port and the 256-word test ROM and test RAM.
- Decodes the core address into ROM, RAM or unmapped regions.
- Sequences each memory's enable, write and address lines around the memories' one-cycle registered read.
- Owns the RAM's tristate data bus and returns read data with a single-cycle acknowledge.

Parameters:
- pAddrWidth, 16: width of the core address.
- pRomBase, 16'h0000: ROM window base; window is 256 words.
- pRamBase, 16'h0100: RAM window base; window is 256 words.
- pWaitStates, 0: extra cycles held in DATA before read capture (0..15).

Ports:
- iClk  in  1  clock; all state changes on the rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iReq  in  1  core request; held high until oAck.
- iWrite  in  1  1 = write, 0 = read; valid with iReq.
- iAddr  in  pAddrWidth  word address.
- iWData  in  32  write data.
- oRData  out  32  read data; valid while oAck=1.
- oAck  out  1  one-cycle completion pulse.
- oErr  out  1  error flag, qualified by oAck (present only with the optional feature, see below).
- oRomAddr  out  8  ROM address.
- oRomEnable  out  1  ROM output enable.
- iRomData  in  32  ROM data.
- oRamAddr  out  8  RAM address.
- oRamEnable  out  1  RAM enable.
- oRamWrite  out  1  RAM write strobe.
- bRamData  inout  32  RAM bidirectional data; the bridge drives it only while oRamWrite=1, otherwise high-Z.

Behaviour:
- Reset (async, any state): state=IDLE; oAck=0, oErr=0, oRData=0; all enables and oRamWrite=0; both address outputs 0; bRamData high-Z; wait counter=0.
- States:
  - IDLE: if iReq is high at a rising edge, latch iAddr, iWrite, iWData and the decoded region; go to ADDR.
  - ADDR: drive the selected memory's address and enable.
    - Write to RAM: oRamWrite=1 and bRamData=latched data; RAM captures at the edge ending ADDR; go to RESP.
    - Read: go to DATA.
  - DATA: hold address and enable so the memory drives its output; counter runs pWaitStates cycles. At the edge ending the last DATA cycle, capture iRomData or bRamData into oRData; go to RESP.
  - RESP: oAck=1 for exactly one cycle, enables deasserted; go to IDLE.
- Latency, counted from the accepting edge: read ack 2+pWaitStates cycles later; write ack 1 cycle later.
- Back-to-back: if iReq is still high in the IDLE cycle after RESP, a new request is accepted. The core deasserts iReq during the oAck cycle to avoid repeating.
- Decode: offset = iAddr - base. A region hits when offset[pAddrWidth-1:8]==0; low 8 bits of offset go to the address output. ROM is checked first when windows overlap.
- Only the selected memory is enabled; the other keeps enable=0.
- ROM write: no memory strobe; ADDR goes straight to RESP; acked.
- Unmapped access: no memory enables; read returns 32'h0; acked after the same latency as a mapped access.
- iReq, iAddr, iWrite and iWData changes outside IDLE are ignored (latched copies are used).
- Reset mid-transaction: bus released immediately; no ack is issued for the aborted access.

Optional Feature:
- Macro: EPRISC_BRIDGE_ERR_EN.
- Defined: oErr exists and equals 1 with oAck for unmapped accesses and ROM writes. Unmapped-read oRData=32'hDEADBEEF.
- Undefined: no oErr port; those accesses complete silently (read data 0, write dropped).

Decomposition:
- Package eprisc_mem_pkg holds:
  - state enum {IDLE, ADDR, DATA, RESP};
  - region enum {REG_ROM, REG_RAM, REG_NONE};
  - the 256-word window size constant;
  - the error pattern 32'hDEADBEEF.
- Sub-module eprisc_mem_decode: combinational address-to-region/offset decode, reused by future peripherals.

Test Plan:
- Read ROM addr 16'h0000, pWaitStates=0 -> oAck 2 cycles after accept, oRData=32'h24413345, oRamEnable never 1.
- Write RAM 16'h0105 data 32'hCAFEF00D, then read 16'h0105 -> write ack after 1 cycle, bRamData driven only during ADDR; read returns 32'hCAFEF00D.
- pWaitStates=3, read ROM 16'h0023 -> ack 5 cycles after accept, oRData=32'h04200000.
- Read 16'h0300 -> ack, oRData=0 (feature off) or 32'hDEADBEEF with oErr=1 (EPRISC_BRIDGE_ERR_EN).
- Assert iRst during DATA of a RAM read -> all enables 0 and bRamData high-Z in the same cycle, no oAck; a following read completes normally.
- iReq held high across 3 ROM reads 16'h0000..16'h0002 -> three one-cycle oAck pulses in consecutive transactions, data 32'h24413345, 32'h25000000, 32'h26000200.

Source files
------------

// File: rtl/eprisc_mem_pkg.sv
// Shared types and constants for the epRISC memory bridge and its address decoder.
package eprisc_mem_pkg;

  // Each memory window covers 256 words; the low 8 offset bits address the word.
  localparam int unsigned WINDOW_WORDS = 256;
  localparam int unsigned WINDOW_BITS  = $clog2(WINDOW_WORDS);

  // Read data returned for unmapped reads when error reporting is built in.
  localparam logic [31:0] ERR_PATTERN = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    REG_ROM,
    REG_RAM,
    REG_NONE
  } region_t;

endpackage

// File: rtl/eprisc_mem_decode.sv
// Combinational address decoder: maps a core word address onto the ROM window,
// the RAM window or nothing, and yields the word offset inside the window.
// The ROM window is checked first, so it wins where the two windows overlap.
module eprisc_mem_decode
  import eprisc_mem_pkg::*;
#(
  parameter int                    pAddrWidth = 16,
  parameter logic [pAddrWidth-1:0] pRomBase   = 16'h0000,
  parameter logic [pAddrWidth-1:0] pRamBase   = 16'h0100
) (
  input  logic [pAddrWidth-1:0]  i_addr,
  output region_t                o_region,
  output logic [WINDOW_BITS-1:0] o_offset
);

  logic [pAddrWidth-1:0] w_rom_off;
  logic [pAddrWidth-1:0] w_ram_off;
  logic                  w_rom_hit;
  logic                  w_ram_hit;

  // Subtraction wraps modulo 2**pAddrWidth, so addresses below a base miss cleanly.
  assign w_rom_off = i_addr - pRomBase;
  assign w_ram_off = i_addr - pRamBase;
  assign w_rom_hit = (w_rom_off[pAddrWidth-1:WINDOW_BITS] == '0);
  assign w_ram_hit = (w_ram_off[pAddrWidth-1:WINDOW_BITS] == '0);

  // Priority select of region and in-window offset.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block leaves it unassigned (which would infer a latch).
    o_region = REG_NONE;
    o_offset = '0;
    if (w_rom_hit) begin
      o_region = REG_ROM;
      o_offset = w_rom_off[WINDOW_BITS-1:0];
    end else if (w_ram_hit) begin
      o_region = REG_RAM;
      o_offset = w_ram_off[WINDOW_BITS-1:0];
    end
  end

endmodule

// File: rtl/eprisc_mem_bridge.sv
// epRISC memory bridge: accepts one core request at a time, sequences the
// test ROM / test RAM (both with a one-cycle registered read) and returns
// read data with a single-cycle acknowledge. Owns the RAM tristate data bus.
// Optional feature macro: EPRISC_BRIDGE_ERR_EN adds oErr (unmapped accesses
// and ROM writes) and returns 32'hDEADBEEF for unmapped reads.
module eprisc_mem_bridge
  import eprisc_mem_pkg::*;
#(
  parameter int                    pAddrWidth  = 16,
  parameter logic [pAddrWidth-1:0] pRomBase    = 16'h0000,
  parameter logic [pAddrWidth-1:0] pRamBase    = 16'h0100,
  parameter int unsigned           pWaitStates = 0
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iReq,
  input  logic                  iWrite,
  input  logic [pAddrWidth-1:0] iAddr,
  input  logic [31:0]           iWData,
  output logic [31:0]           oRData,
  output logic                  oAck,
`ifdef EPRISC_BRIDGE_ERR_EN
  output logic                  oErr,
`endif
  output logic [7:0]            oRomAddr,
  output logic                  oRomEnable,
  input  logic [31:0]           iRomData,
  output logic [7:0]            oRamAddr,
  output logic                  oRamEnable,
  output logic                  oRamWrite,
  inout  wire  [31:0]           bRamData
);

  localparam logic [3:0] WAIT_LAST = 4'(pWaitStates);

  state_t                 r_state;
  state_t                 w_next_state;
  region_t                r_region;
  logic [WINDOW_BITS-1:0] r_offset;
  logic                   r_write;
  logic [31:0]            r_wdata;
  logic [3:0]             r_wait_cnt;
  logic [31:0]            r_rdata;

  region_t                w_dec_region;
  logic [WINDOW_BITS-1:0] w_dec_offset;
  logic                   w_mem_sel;
  logic                   w_wait_done;
  logic [31:0]            w_read_data;

  eprisc_mem_decode #(
    .pAddrWidth (pAddrWidth),
    .pRomBase   (pRomBase),
    .pRamBase   (pRamBase)
  ) u_decode (
    .i_addr   (iAddr),
    .o_region (w_dec_region),
    .o_offset (w_dec_offset)
  );

  // Memories see address and enable only while the access is in flight.
  assign w_mem_sel   = (r_state == ADDR) || (r_state == DATA);
  assign w_wait_done = (r_wait_cnt == WAIT_LAST);
  assign oRData      = r_rdata;

  // The bridge drives the RAM bus only during the write strobe; otherwise the RAM owns it.
  assign bRamData = oRamWrite ? r_wdata : 'z;

`ifdef EPRISC_BRIDGE_ERR_EN
  assign oErr = (r_state == RESP) &&
                ((r_region == REG_NONE) || ((r_region == REG_ROM) && r_write));
`endif

  // Read-data source for the capture at the end of DATA.
  always_comb begin
    w_read_data = '0;
    case (r_region)
      REG_ROM: w_read_data = iRomData;
      REG_RAM: w_read_data = bRamData;
`ifdef EPRISC_BRIDGE_ERR_EN
      default: w_read_data = ERR_PATTERN;
`else
      default: w_read_data = '0;
`endif
    endcase
  end

  // Next-state logic and memory-side outputs.
  always_comb begin
    w_next_state = r_state;
    oAck         = 1'b0;
    oRomEnable   = 1'b0;
    oRomAddr     = '0;
    oRamEnable   = 1'b0;
    oRamAddr     = '0;
    oRamWrite    = 1'b0;

    case (r_state)
      IDLE:    if (iReq) w_next_state = ADDR;
      ADDR:    w_next_state = r_write ? RESP : DATA;
      DATA:    if (w_wait_done) w_next_state = RESP;
      RESP:    begin
                 w_next_state = IDLE;
                 oAck         = 1'b1;
               end
      default: w_next_state = IDLE;
    endcase

    if (w_mem_sel) begin
      case (r_region)
        REG_ROM: begin
          oRomEnable = 1'b1;
          oRomAddr   = r_offset;
        end
        REG_RAM: begin
          oRamEnable = 1'b1;
          oRamAddr   = r_offset;
          oRamWrite  = r_write && (r_state == ADDR);
        end
        default: ;
      endcase
    end
  end

  // State register, request latch, wait counter and read-data capture.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      // NOTE: the latched request fields are reset too, so the outputs derived from them are defined straight out of reset.
      r_state    <= IDLE;
      r_region   <= REG_NONE;
      r_offset   <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_wait_cnt <= '0;
      r_rdata    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          r_wait_cnt <= '0;
          if (iReq) begin
            r_region <= w_dec_region;
            r_offset <= w_dec_offset;
            r_write  <= iWrite;
            r_wdata  <= iWData;
          end
        end
        DATA: begin
          if (w_wait_done) r_rdata <= w_read_data;
          else             r_wait_cnt <= r_wait_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eprisc_mem_bridge.sv
// Self-checking bench for eprisc_mem_bridge: two bridges (0 and 3 wait states),
// each with a registered-read ROM and RAM model, checked against a reference
// model that works from address windows, latency rules and a shadow RAM image.
module tb_eprisc_mem_bridge;

`ifdef EPRISC_BRIDGE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [15:0] ROM_BASE = 16'h0000;
  localparam logic [15:0] RAM_BASE = 16'h0100;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic        ram_en;
    logic [7:0]  ram_addr;
    logic        ram_wr;
    logic [31:0] bus;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_mem;
  logic        req0, req1, wr;
  logic [15:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata0, rdata1, rom_data0, rom_data1, ram_q0, ram_q1;
  logic        ack0, ack1, err0, err1;
  logic [7:0]  rom_addr0, rom_addr1, ram_addr0, ram_addr1;
  logic        rom_en0, rom_en1, ram_en0, ram_en1, ram_wr0, ram_wr1;
  wire  [31:0] bus0, bus1;

  logic [31:0] rom_img  [256];
  logic [31:0] ram_mem0 [256];
  logic [31:0] ram_mem1 [256];
  logic [31:0] ram_ref0 [256];
  logic [31:0] ram_ref1 [256];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  eprisc_mem_bridge #(.pWaitStates(0)) u_dut0 (
    .iClk(clk), .iRst(rst), .iReq(req0), .iWrite(wr), .iAddr(addr), .iWData(wdata),
    .oRData(rdata0), .oAck(ack0),
`ifdef EPRISC_BRIDGE_ERR_EN
    .oErr(err0),
`endif
    .oRomAddr(rom_addr0), .oRomEnable(rom_en0), .iRomData(rom_data0),
    .oRamAddr(ram_addr0), .oRamEnable(ram_en0), .oRamWrite(ram_wr0), .bRamData(bus0)
  );

  eprisc_mem_bridge #(.pWaitStates(3)) u_dut1 (
    .iClk(clk), .iRst(rst), .iReq(req1), .iWrite(wr), .iAddr(addr), .iWData(wdata),
    .oRData(rdata1), .oAck(ack1),
`ifdef EPRISC_BRIDGE_ERR_EN
    .oErr(err1),
`endif
    .oRomAddr(rom_addr1), .oRomEnable(rom_en1), .iRomData(rom_data1),
    .oRamAddr(ram_addr1), .oRamEnable(ram_en1), .oRamWrite(ram_wr1), .bRamData(bus1)
  );

`ifndef EPRISC_BRIDGE_ERR_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  function automatic logic [31:0] ram_init(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // ROM models: one-cycle registered read.
  always @(posedge clk) if (rom_en0) rom_data0 <= rom_img[rom_addr0];
  always @(posedge clk) if (rom_en1) rom_data1 <= rom_img[rom_addr1];

  // RAM models: write on strobe, otherwise registered read.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) ram_mem0[i] <= ram_init(i);
    end else if (ram_en0) begin
      if (ram_wr0) ram_mem0[ram_addr0] <= bus0;
      else         ram_q0 <= ram_mem0[ram_addr0];
    end
  end
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) ram_mem1[i] <= ram_init(i);
    end else if (ram_en1) begin
      if (ram_wr1) ram_mem1[ram_addr1] <= bus1;
      else         ram_q1 <= ram_mem1[ram_addr1];
    end
  end

  // RAM side: read data while selected, parked at zero while deselected, released
  // only during the bridge's write strobe. A nonzero value while the RAM is
  // deselected means the bridge is driving the bus when it should not.
  assign bus0 = ram_wr0 ? 'z : (ram_en0 ? ram_q0 : 32'h0);
  assign bus1 = ram_wr1 ? 'z : (ram_en1 ? ram_q1 : 32'h0);

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_total++;
    assert (observed === expected) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic obs_t observe(input int d);
    obs_t o;
    if (d == 0) o = '{ack0, err0, rdata0, rom_en0, rom_addr0, ram_en0, ram_addr0, ram_wr0, bus0};
    else        o = '{ack1, err1, rdata1, rom_en1, rom_addr1, ram_en1, ram_addr1, ram_wr1, bus1};
    return o;
  endfunction

  // Reference decode: 0 = ROM, 1 = RAM, 2 = unmapped.
  function automatic int region_of(input logic [15:0] a, output logic [7:0] off);
    logic [15:0] diff;
    diff = a - ROM_BASE;
    if (diff < 16'd256) begin off = diff[7:0]; return 0; end
    diff = a - RAM_BASE;
    if (diff < 16'd256) begin off = diff[7:0]; return 1; end
    off = 8'h00;
    return 2;
  endfunction

  task automatic set_req(input int d, input logic v);
    if (d == 0) req0 = v;
    else        req1 = v;
  endtask

  // One transaction on bridge d; with keep set, iReq stays high for a back-to-back follow-up.
  task automatic txn(input int d, input bit w, input logic [15:0] a, input logic [31:0] dat,
                     input bit keep, input string tag);
    logic [7:0]  off;
    int          rid, exp_lat, lat, wr_cycles;
    logic [31:0] exp_data, bus_at_wr;
    bit          exp_err, other_en;
    logic [18:0] exp_vec;
    obs_t        o;

    rid      = region_of(a, off);
    exp_lat  = w ? 1 : 2 + (d == 0 ? 0 : 3);
    exp_err  = ERR_EN && (rid == 2 || (rid == 0 && w));
    exp_data = (rid == 0) ? rom_img[off] :
               (rid == 1) ? (d == 0 ? ram_ref0[off] : ram_ref1[off]) :
               (ERR_EN ? 32'hDEADBEEF : 32'h0);
    if (w && rid == 1) begin
      if (d == 0) ram_ref0[off] = dat;
      else        ram_ref1[off] = dat;
    end
    exp_vec = {rid == 0, (rid == 0) ? off : 8'h00, rid == 1, (rid == 1) ? off : 8'h00, rid == 1 && w};

    addr  = a;
    wr    = w;
    wdata = dat;
    set_req(d, 1'b1);
    @(posedge clk); #1;

    lat = -1; other_en = 1'b0; wr_cycles = 0; bus_at_wr = 32'h0;
    for (int k = 0; k <= 40 && lat < 0; k++) begin
      o = observe(d);
      if (k == 0) begin
        check({tag, " addr/enable"}, 64'({o.rom_en, o.rom_addr, o.ram_en, o.ram_addr, o.ram_wr}), 64'(exp_vec));
        addr  = 16'($urandom);
        wr    = 1'($urandom);
        wdata = $urandom;
      end
      if ((o.rom_en && rid != 0) || (o.ram_en && rid != 1)) other_en = 1'b1;
      if (o.ram_wr) begin
        wr_cycles++;
        bus_at_wr = o.bus;
      end
      if (o.ack) begin
        lat = k;
        if (!w) check({tag, " rdata"}, 64'(o.rdata), 64'(exp_data));
        check({tag, " err"}, 64'(o.err), 64'(exp_err));
        check({tag, " resp enables"}, 64'({o.rom_en, o.ram_en, o.ram_wr}), 64'(0));
        if (!keep) set_req(d, 1'b0);
      end else begin
        @(posedge clk); #1;
      end
    end
    if (lat < 0) set_req(d, 1'b0);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " wrong memory enabled"}, 64'(other_en), 64'(0));
    check({tag, " write strobes"}, 64'(wr_cycles), 64'((rid == 1 && w) ? 1 : 0));
    if (rid == 1 && w) check({tag, " write bus data"}, 64'(bus_at_wr), 64'(dat));
    @(posedge clk); #1;
    o = observe(d);
    check({tag, " ack single pulse"}, 64'(o.ack), 64'(0));
  endtask

  task automatic random_txn(input int d, input string tag);
    logic [15:0] a;
    logic [15:0] corners [6];
    corners = '{16'h00FF, 16'h0100, 16'h01FF, 16'h0200, 16'hFFFF, 16'h0000};
    case ($urandom_range(0, 3))
      0:       a = ROM_BASE + 16'($urandom_range(0, 255));
      1:       a = RAM_BASE + 16'($urandom_range(0, 255));
      2:       a = 16'h0200 + 16'($urandom_range(0, 16'hFDFF));
      default: a = corners[$urandom_range(0, 5)];
    endcase
    txn(d, 1'($urandom), a, $urandom, 1'b0, tag);
  endtask

  initial begin
    obs_t o;
    for (int i = 0; i < 256; i++) begin
      rom_img[i]  = $urandom;
      ram_ref0[i] = ram_init(i);
      ram_ref1[i] = ram_init(i);
    end
    rom_img[8'h00] = 32'h24413345;
    rom_img[8'h01] = 32'h25000000;
    rom_img[8'h02] = 32'h26000200;
    rom_img[8'h23] = 32'h04200000;

    rst = 1'b1; init_mem = 1'b1; req0 = 1'b0; req1 = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      o = observe(d);
      check("reset outputs", 64'({o.ack, o.err, o.rom_en, o.rom_addr, o.ram_en, o.ram_addr, o.ram_wr}), 64'(0));
      check("reset rdata", 64'(o.rdata), 64'(0));
      check("reset bus released", 64'(o.bus), 64'(0));
    end
    @(negedge clk);
    rst = 1'b0; init_mem = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    txn(0, 1'b0, 16'h0000, 32'h0, 1'b0, "rom read 0000");
    txn(0, 1'b1, 16'h0105, 32'hCAFEF00D, 1'b0, "ram write 0105");
    txn(0, 1'b0, 16'h0105, 32'h0, 1'b0, "ram read 0105");
    txn(1, 1'b0, 16'h0023, 32'h0, 1'b0, "rom read 0023 ws3");
    txn(0, 1'b0, 16'h0300, 32'h0, 1'b0, "unmapped read 0300");
    txn(0, 1'b1, 16'h0300, 32'h12345678, 1'b0, "unmapped write 0300");
    txn(0, 1'b1, 16'h0010, 32'h87654321, 1'b0, "rom write 0010");
    txn(0, 1'b0, 16'h0010, 32'h0, 1'b0, "rom read 0010");
    txn(1, 1'b1, 16'h01FF, 32'h0BADF00D, 1'b0, "ram write 01ff ws3");
    txn(1, 1'b0, 16'h01FF, 32'h0, 1'b0, "ram read 01ff ws3");

    // Reset in the middle of a RAM read's DATA phase.
    addr = 16'h0105; wr = 1'b0; wdata = 32'h0; req0 = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    o = observe(0);
    check("abort enables", 64'({o.rom_en, o.ram_en, o.ram_wr, o.ack}), 64'(0));
    check("abort bus released", 64'(o.bus), 64'(0));
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort no ack", 64'(ack0), 64'(0));
    end
    txn(0, 1'b0, 16'h0105, 32'h0, 1'b0, "read after abort");

    // Back-to-back ROM reads with iReq held high throughout.
    txn(0, 1'b0, 16'h0000, 32'h0, 1'b1, "b2b rom 0000");
    txn(0, 1'b0, 16'h0001, 32'h0, 1'b1, "b2b rom 0001");
    txn(0, 1'b0, 16'h0002, 32'h0, 1'b0, "b2b rom 0002");

    // Randomized traffic on both bridges.
    for (int i = 0; i < 40; i++) random_txn(0, "random ws0");
    for (int i = 0; i < 15; i++) random_txn(1, "random ws3");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
